mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit beside the ALU in the execute stage of the MIPS_R2000 core.
- Consumes the GPR read ports (rs to DataIn1, rt to DataIn2) and holds the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- MFHI/MFLO read HI and LO directly.
- Control stalls the PCU while Busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is verified.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-low. RST=0 clears all state immediately.
- Start  input  1  request strobe. Sampled only when idle.
- MDOp  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. 110 and 111 are no-ops.
- DataIn1  input  WIDTH  rs value (multiplicand/dividend, or MTHI/MTLO source).
- DataIn2  input  WIDTH  rt value (multiplier/divisor).
- Busy  output  1  an iterative operation is in flight.
- Done  output  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset (RST low, async): HI=0, LO=0, Busy=0, Done=0, state=IDLE, iteration counter=0, internal operand registers=0.
- States: IDLE, RUN, FIX. Busy is 1 exactly when the state is not IDLE. Busy is decoded from the state register; no combinational path from Start.
- IDLE, Start=1, MDOp=100: HI<=DataIn1 at that edge. Stay IDLE. No Done pulse.
- IDLE, Start=1, MDOp=101: LO<=DataIn1 at that edge. Stay IDLE. No Done pulse.
- IDLE, Start=1, MDOp in 000–011, at edge E0:
  - Latch the operation type and signedness.
  - Latch the operand magnitudes: absolute value for signed ops, raw for unsigned.
  - Latch the result sign: product sign = sign1 XOR sign2; quotient sign = sign1 XOR sign2; remainder sign = sign1.
  - Clear the accumulator, load counter=WIDTH-1, go to RUN.
- IDLE, Start=1, MDOp 110/111: ignored.
- RUN: one radix-2 step per edge.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first.
  - Counter decrements each step. The step taken with counter=0 moves the state to FIX (WIDTH steps, edges E1..E32).
- FIX, edge E33:
  - Apply two's-complement sign correction.
  - Write the 64-bit product as {HI,LO}, or write HI=remainder and LO=quotient.
  - Go to IDLE. Done=1 for the cycle after E33, 0 otherwise.
- Latency: HI/LO are valid, Busy=0 and Done=1 after edge E33. Busy is high for exactly 33 cycles.
- HI and LO keep their old values throughout RUN. They change only at FIX or via MTHI/MTLO.
- Start while Busy: ignored entirely, including MTHI/MTLO. Control must hold the request.
- DataIn1/DataIn2 may change after E0 with no effect on the result.
- Divide by zero (DataIn2=0 at E0): full 33-cycle latency. LO=32'hFFFFFFFF, HI=DataIn1 as latched (raw), for both DIV and DIVU.
- Signed division truncates toward zero. Remainder takes the dividend's sign.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- Products are the full 64 bits. No overflow condition exists.
- RST low mid-operation: abort immediately to reset values. No Done pulse.

Test Plan:
- MULT DataIn1=0xFFFFFFFD (-3), DataIn2=5 -> Busy high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1, Done one cycle.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIVU 100/7 -> LO=14, HI=2.
- DIV -7 (0xFFFFFFF9) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234/0 -> after 33 cycles LO=0xFFFFFFFF, HI=0x00001234, Done pulses.
- During MULT 6×7, assert Start with MDOp=100 and DataIn1=0xAAAA, and change DataIn1/DataIn2 -> ignored. Final HI=0, LO=42. A subsequent idle MTLO 0x55 -> LO=0x55 next edge, HI unchanged, no Done.
- Drop RST mid-DIV at cycle 10 -> HI=LO=0, Busy=0 immediately. After release, no Done pulse. A new MULT 2×3 completes with LO=6.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit that owns the architectural HI/LO registers.
// Takes 33 cycles per MULT/DIV (32 steps plus a sign fix-up); MTHI/MTLO write in one edge.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] DataIn1,
  input  logic [WIDTH-1:0] DataIn2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  // Even MDOp codes (MULT, DIV) are the signed variants.
  logic             sign1, sign2;
  logic [WIDTH-1:0] mag1, mag2;

  assign sign1 = DataIn1[WIDTH-1] & ~MDOp[0];
  assign sign2 = DataIn2[WIDTH-1] & ~MDOp[0];
  assign mag1  = sign1 ? -DataIn1 : DataIn1;
  assign mag2  = sign2 ? -DataIn2 : DataIn2;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits becoming quotient bits}, shifted left.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  // With a zero divisor every trial subtract succeeds, so the remainder ends up as the
  // dividend magnitude and the normal remainder sign fix restores the raw dividend for HI.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = div_zero ? {WIDTH{1'b1}} : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            case (MDOp)
              3'b100: hi_q <= DataIn1;
              3'b101: lo_q <= DataIn1;
              3'b000, 3'b001, 3'b010, 3'b011: begin
                is_div   <= MDOp[1];
                neg_res  <= sign1 ^ sign2;
                neg_rem  <= sign1;
                div_zero <= MDOp[1] && (DataIn2 == '0);
                opnd     <= MDOp[1] ? mag2 : mag1;
                acc      <= {{WIDTH{1'b0}}, (MDOp[1] ? mag1 : mag2)};
                cnt      <= CW'(WIDTH - 1);
                state    <= S_RUN;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          acc <= is_div ? div_next : mul_next;
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Busy = (state != S_IDLE);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, hand-written corner sequences and
// random operations compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        CLK;
  logic        RST;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] DataIn1;
  logic [31:0] DataIn2;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .MDOp(MDOp),
    .DataIn1(DataIn1), .DataIn2(DataIn2),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: full-width arithmetic on 64-bit integers, truncating signed division.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    res = '0;
    case (op)
      3'b000: res = sa * sb;
      3'b001: res = ua * ub;
      default: begin
        if (b == 32'h0) begin
          res = {a, 32'hFFFFFFFF};
        end else if (op == 3'b010) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {a % b, a / b};
        end
      end
    endcase
    return res;
  endfunction

  // Issues one MULT/DIV, scrambles the operand inputs while it runs, and optionally
  // pulses a MTHI request mid-operation; checks latency, HI/LO hold, result and Done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name, input bit disturb);
    logic [63:0] old;
    int n;
    bit held, early_done;
    @(negedge CLK);
    old     = {HI, LO};
    Start   = 1'b1;
    MDOp    = op;
    DataIn1 = a;
    DataIn2 = b;
    @(posedge CLK);
    @(negedge CLK);
    n = 0;
    held = 1'b1;
    early_done = 1'b0;
    while (Busy && n < 40) begin
      if ({HI, LO} !== old) held = 1'b0;
      if (Done) early_done = 1'b1;
      if (disturb && n >= 4 && n < 8) begin
        Start   = 1'b1;
        MDOp    = 3'b100;
        DataIn1 = 32'h0000AAAA;
      end else begin
        Start   = 1'b0;
        MDOp    = 3'($urandom_range(0, 7));
        DataIn1 = $urandom;
      end
      DataIn2 = $urandom;
      @(negedge CLK);
      n++;
    end
    Start = 1'b0;
    check({name, " busy_cycles"}, 64'(n), 64'd33);
    check({name, " hilo_held"}, 64'(held), 64'd1);
    check({name, " no_early_done"}, 64'(early_done), 64'd0);
    check({name, " done_pulse"}, 64'(Done), 64'd1);
    check({name, " result"}, {HI, LO}, exp);
    @(negedge CLK);
    check({name, " done_cleared"}, 64'(Done), 64'd0);
  endtask

  // Single-edge MTHI/MTLO/no-op request while idle.
  task automatic idle_op(input logic [2:0] op, input logic [31:0] val,
                         input logic [63:0] exp, input string name);
    @(negedge CLK);
    Start   = 1'b1;
    MDOp    = op;
    DataIn1 = val;
    DataIn2 = $urandom;
    @(posedge CLK);
    #1;
    check({name, " hilo"}, {HI, LO}, exp);
    check({name, " busy_done"}, {62'h0, Busy, Done}, 64'd0);
    @(negedge CLK);
    Start = 1'b0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int sel;
    bit stray;

    vecs[0] = '{3'b000, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5"};
    vecs[1] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[2] = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"};
    vecs[3] = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
    vecs[4] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
    vecs[5] = '{3'b011, 32'h1234,     32'h0,        32'h00001234, 32'hFFFFFFFF, "divu_by0"};
    vecs[6] = '{3'b010, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0"};
    vecs[7] = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_m2"};

    RST = 1'b0; Start = 1'b0; MDOp = 3'b0; DataIn1 = '0; DataIn2 = '0;
    repeat (2) @(negedge CLK);
    check("reset hilo", {HI, LO}, 64'h0);
    check("reset busy_done", {62'h0, Busy, Done}, 64'd0);
    RST = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, vecs[i].name, 1'b0);

    // Requests and operand changes during a multiply must be ignored.
    run_op(3'b000, 32'd6, 32'd7, 64'd42, "mult_6x7_disturbed", 1'b1);
    idle_op(3'b101, 32'h55, {32'h0, 32'h55}, "mtlo_55");
    idle_op(3'b100, 32'h11, {32'h11, 32'h55}, "mthi_11");
    idle_op(3'b110, 32'hDEAD, {32'h11, 32'h55}, "noop_110");
    idle_op(3'b111, 32'hBEEF, {32'h11, 32'h55}, "noop_111");

    // Reset in the middle of a divide aborts without a Done pulse.
    @(negedge CLK);
    Start = 1'b1; MDOp = 3'b010; DataIn1 = 32'd1000; DataIn2 = 32'd3;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    check("pre_reset busy", 64'(Busy), 64'd1);
    RST = 1'b0;
    #1;
    check("midrst hilo", {HI, LO}, 64'h0);
    check("midrst busy_done", {62'h0, Busy, Done}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    stray = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (Busy || Done) stray = 1'b1;
    end
    check("after_reset quiet", 64'(stray), 64'd0);
    run_op(3'b000, 32'd2, 32'd3, 64'd6, "mult_2x3_after_reset", 1'b0);

    for (int k = 0; k < 60; k++) begin
      op  = 3'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
        3: begin a = -32'($urandom_range(0, 1000)); b = -32'($urandom_range(1, 50)); end
        default: ;
      endcase
      run_op(op, a, b, model(op, a, b), $sformatf("rand%0d_op%0d", k, op), k[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
